int_controller: RTL and testbench

//  Programmable interrupt controller between the peripherals and CP0. Samples N_SRC device

---
 rtl/int_controller.sv | 105 ++++++++++
 tb/tb_int_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/int_controller.sv
// Programmable interrupt controller: per-source level/edge latching, enable masking,
// claim/complete handshake with in-service tracking, and a small MMIO register window.
module int_controller #(
   parameter int N_SRC = 6
) (
   input  logic             clk,
   input  logic             RESET_N,
   input  logic [N_SRC-1:0] IRQ_SRC,
   input  logic             SEL,
   input  logic [2:0]       A,
   input  logic             WE,
   input  logic             RE,
   input  logic [31:0]      WD,
   output logic [31:0]      RD,
   output logic [N_SRC-1:0] HWInt
);

   localparam logic [2:0] A_PEND  = 3'd0;
   localparam logic [2:0] A_EN    = 3'd1;
   localparam logic [2:0] A_MODE  = 3'd2;
   localparam logic [2:0] A_CLAIM = 3'd3;
   localparam logic [2:0] A_CMPL  = 3'd4;
   localparam logic [2:0] A_INSV  = 3'd5;

   logic [N_SRC-1:0] smp, pend, en, mode, insv;
   logic [N_SRC-1:0] elig, edge_set, w1c, mode_chg, claim_oh, cmpl_oh, pend_nxt;
   logic [4:0]       claim_id;
   logic             claim_hit, do_claim, wr;
   logic             unused_wd;

   assign unused_wd = ^WD;
   assign wr        = SEL & WE;
   assign elig      = pend & en & ~insv;
   assign edge_set  = IRQ_SRC & ~smp;

   // lowest index wins: scan downward so the last hit is the smallest id
   always_comb begin
      claim_id  = '0;
      claim_hit = 1'b0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (elig[i]) begin
            claim_id  = 5'(i);
            claim_hit = 1'b1;
         end
      end
   end

   // a simultaneous write suppresses the claim side effect
   assign do_claim = SEL & RE & ~WE & (A == A_CLAIM) & claim_hit;

   always_comb begin
      claim_oh = '0;
      cmpl_oh  = '0;
      w1c      = '0;
      mode_chg = '0;
      if (do_claim)
         claim_oh = N_SRC'(1) << claim_id;
      if (wr && (A == A_CMPL) && (WD[4:0] < 5'(N_SRC)))
         cmpl_oh = N_SRC'(1) << WD[4:0];
      if (wr && (A == A_PEND))
         w1c = WD[N_SRC-1:0];
      if (wr && (A == A_MODE))
         mode_chg = WD[N_SRC-1:0] ^ mode;
   end

   // edge bits: a new edge beats any clear; level bits follow the line; mode change flushes
   assign pend_nxt = ~mode_chg &
                     ((mode & (edge_set | (pend & ~(w1c | claim_oh)))) |
                      (~mode & IRQ_SRC));

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         smp   <= '0;
         pend  <= '0;
         en    <= '0;
         mode  <= '0;
         insv  <= '0;
         HWInt <= '0;
      end else begin
         smp   <= IRQ_SRC;
         pend  <= pend_nxt;
         insv  <= (insv | claim_oh) & ~cmpl_oh;
         HWInt <= elig;
         if (wr && (A == A_EN))
            en <= WD[N_SRC-1:0];
         if (wr && (A == A_MODE))
            mode <= WD[N_SRC-1:0];
      end
   end

   always_comb begin
      RD = '0;
      if (SEL) begin
         case (A)
            A_PEND:  RD = 32'(pend);
            A_EN:    RD = 32'(en);
            A_MODE:  RD = 32'(mode);
            A_CLAIM: RD = claim_hit ? {1'b1, 26'b0, claim_id} : 32'd0;
            A_INSV:  RD = 32'(insv);
            default: RD = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed scenarios plus random traffic, all checked against
// a per-source behavioural model of pending/enable/mode/in-service bookkeeping.
module tb_int_controller;
   localparam int N = 6;

   logic          clk = 1'b0;
   logic          RESET_N = 1'b0;
   logic [N-1:0]  IRQ_SRC = '0;
   logic          SEL = 1'b0;
   logic [2:0]    A = '0;
   logic          WE = 1'b0;
   logic          RE = 1'b0;
   logic [31:0]   WD = '0;
   logic [31:0]   RD;
   logic [N-1:0]  HWInt;

   int total = 0;
   int bad   = 0;

   int_controller #(.N_SRC(N)) dut (
      .clk(clk), .RESET_N(RESET_N), .IRQ_SRC(IRQ_SRC), .SEL(SEL), .A(A),
      .WE(WE), .RE(RE), .WD(WD), .RD(RD), .HWInt(HWInt)
   );

   always #5 clk = ~clk;

   bit [N-1:0] m_pend, m_en, m_mode, m_insv, m_smp, m_hw;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = '0; m_en = '0; m_mode = '0; m_insv = '0; m_smp = '0; m_hw = '0;
   endtask

   function automatic int elig_id();
      for (int i = 0; i < N; i++)
         if (m_pend[i] && m_en[i] && !m_insv[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] model_rd(input bit sel, input int a);
      int id;
      if (!sel) return 32'd0;
      id = elig_id();
      case (a)
         0: return 32'(m_pend);
         1: return 32'(m_en);
         2: return 32'(m_mode);
         3: return (id >= 0) ? (32'h8000_0000 + 32'(id)) : 32'd0;
         5: return 32'(m_insv);
         default: return 32'd0;
      endcase
   endfunction

   // one bus cycle: drive, check RD mid-cycle, advance model across the edge, check HWInt
   task automatic cyc(input logic [N-1:0] irq, input bit sel, input int a, input bit we,
                      input bit re, input logic [31:0] wd, output logic [31:0] rd_seen);
      int id;
      bit claim, set_e, clr;
      bit [N-1:0] n_pend, n_en, n_mode, n_insv, n_hw;
      IRQ_SRC = irq; SEL = sel; A = a[2:0]; WE = we; RE = re; WD = wd;
      #1;
      rd_seen = RD;
      chk("rd", RD, model_rd(sel, a));
      id = elig_id();
      claim = sel && re && !we && (a == 3) && (id >= 0);
      for (int i = 0; i < N; i++) begin
         if (sel && we && a == 2 && (wd[i] != m_mode[i]))
            n_pend[i] = 1'b0;
         else if (!m_mode[i])
            n_pend[i] = irq[i];
         else begin
            set_e = irq[i] && !m_smp[i];
            clr   = (sel && we && a == 0 && wd[i]) || (claim && id == i);
            n_pend[i] = set_e || (m_pend[i] && !clr);
         end
         n_hw[i]   = m_pend[i] && m_en[i] && !m_insv[i];
         n_en[i]   = (sel && we && a == 1) ? wd[i] : m_en[i];
         n_mode[i] = (sel && we && a == 2) ? wd[i] : m_mode[i];
         n_insv[i] = m_insv[i];
         if (claim && id == i) n_insv[i] = 1'b1;
         if (sel && we && a == 4 && int'(wd[4:0]) == i) n_insv[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      m_pend = n_pend; m_en = n_en; m_mode = n_mode; m_insv = n_insv;
      m_hw = n_hw; m_smp = irq;
      chk("hwint", 32'(HWInt), 32'(m_hw));
   endtask

   initial begin
      logic [31:0] r;
      logic [N-1:0] irq;
      int a;
      model_reset();
      SEL = 1'b1; A = 3'd1;
      #3;
      chk("reset_hwint", 32'(HWInt), 32'd0);
      chk("reset_rd_en", RD, 32'd0);
      @(posedge clk); #1;
      RESET_N = 1'b1;

      // edge source 0: pulse reaches HWInt two edges later and holds
      cyc('0, 1, 1, 1, 0, 32'h3F, r);
      cyc('0, 1, 2, 1, 0, 32'h01, r);
      cyc(6'h01, 0, 0, 0, 0, 0, r);
      cyc('0, 0, 0, 0, 0, 0, r);
      chk("edge_hwint", 32'(HWInt), 32'h01);
      cyc('0, 0, 0, 0, 0, 0, r);
      chk("edge_hwint_hold", 32'(HWInt), 32'h01);
      cyc('0, 1, 3, 0, 1, 0, r);
      chk("claim0_rd", r, 32'h8000_0000);
      cyc('0, 1, 5, 0, 0, 0, r);
      chk("claim0_insv", r, 32'h01);
      chk("claim0_hwint", 32'(HWInt), 32'h00);
      cyc('0, 1, 0, 0, 0, 0, r);
      chk("claim0_pend", r, 32'h00);
      cyc('0, 1, 4, 1, 0, 32'd0, r);
      cyc('0, 1, 5, 0, 0, 0, r);
      chk("cmpl0_insv", r, 32'h00);

      // level sources 2 and 5 nest
      cyc('0, 1, 2, 1, 0, 32'h00, r);
      cyc(6'h24, 1, 1, 1, 0, 32'h24, r);
      cyc(6'h24, 0, 0, 0, 0, 0, r);
      cyc(6'h24, 1, 3, 0, 1, 0, r);
      chk("lvl_claim2", r, 32'h8000_0002);
      cyc(6'h24, 1, 3, 0, 1, 0, r);
      chk("lvl_claim5", r, 32'h8000_0005);
      cyc(6'h24, 1, 0, 0, 0, 0, r);
      chk("lvl_pend_stays", r, 32'h24);
      chk("lvl_hwint", 32'(HWInt), 32'h00);
      cyc(6'h24, 1, 4, 1, 0, 32'd2, r);
      cyc(6'h24, 1, 4, 1, 0, 32'd5, r);
      cyc('0, 1, 5, 0, 0, 0, r);
      chk("lvl_insv_clear", r, 32'h00);
      cyc('0, 0, 0, 0, 0, 0, r);

      // new edge in the same cycle as W1C: set wins
      cyc('0, 1, 2, 1, 0, 32'h01, r);
      cyc('0, 1, 1, 1, 0, 32'h01, r);
      cyc(6'h01, 1, 0, 1, 0, 32'h01, r);
      cyc('0, 1, 0, 0, 0, 0, r);
      chk("w1c_race_pend", r, 32'h01);
      cyc('0, 1, 1, 1, 0, 32'h00, r);
      cyc('0, 0, 0, 0, 0, 0, r);
      chk("en0_hwint", 32'(HWInt), 32'h00);
      cyc('0, 1, 3, 0, 1, 0, r);
      chk("en0_claim", r, 32'h0);
      cyc('0, 1, 0, 1, 0, 32'h3F, r);

      // WE&RE on CLAIM suppresses claim; COMPLETE 31 ignored
      cyc('0, 1, 2, 1, 0, 32'h02, r);
      cyc('0, 1, 1, 1, 0, 32'h02, r);
      cyc(6'h02, 0, 0, 0, 0, 0, r);
      cyc('0, 1, 3, 1, 1, 32'hFFFF_FFFF, r);
      cyc('0, 1, 5, 0, 0, 0, r);
      chk("werc_insv", r, 32'h00);
      cyc('0, 1, 4, 1, 0, 32'd31, r);
      cyc('0, 1, 0, 0, 0, 0, r);
      chk("cmpl31_pend", r, 32'h02);
      cyc('0, 1, 5, 0, 0, 0, r);
      chk("cmpl31_insv", r, 32'h00);

      // reset dropped in the middle of a claim
      cyc('0, 1, 3, 0, 1, 0, r);
      chk("pre_rst_claim", r, 32'h8000_0001);
      SEL = 1'b1; A = 3'd5; WE = 1'b0; RE = 1'b0;
      #2;
      RESET_N = 1'b0;
      #1;
      chk("rst_insv", RD, 32'd0);
      chk("rst_hwint", 32'(HWInt), 32'd0);
      A = 3'd0; #1;
      chk("rst_pend", RD, 32'd0);
      A = 3'd1; #1;
      chk("rst_en", RD, 32'd0);
      model_reset();
      @(posedge clk); #1;
      RESET_N = 1'b1;

      // random traffic
      irq = '0;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 3) == 0) irq = N'($urandom);
         a = int'($urandom_range(0, 7));
         cyc(irq, $urandom_range(0, 7) != 0, a, $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1,
             (a == 4) ? 32'($urandom_range(0, 7)) :
             (a == 2 && $urandom_range(0, 3) != 0) ? 32'(m_mode) : $urandom, r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
